// File: rtl/return_stack.sv
// Circular return-address stack for the PIC16F84 core. Sits beside the program counter:
// CALL pushes the PC's return address, RETURN-class instructions pop it back.
module return_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 10,
    parameter int PW    = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic          push,
    input  logic          pop,
    input  logic          clr_err,
    input  logic [AW-1:0] IN_PC,
    output logic [AW-1:0] OUT_TOS,
    output logic [PW:0]   level,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [PW:0] FULL_LEVEL = DEPTH[PW:0];

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW:0]   level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic [PW-1:0] tosPtr;
    logic          isEmpty, isFull;
    logic          doPush, doReplace, doPop;
    logic          memWe;
    logic [PW-1:0] memAddr;

    assign tosPtr  = wp_q - 1'b1;
    assign isEmpty = (level_q == '0);
    assign isFull  = (level_q == FULL_LEVEL);

    // Push together with pop means "replace top", unless the stack is empty, where it is a plain push.
    assign doPush    = en && push && (!pop || isEmpty);
    assign doReplace = en && push && pop && !isEmpty;
    assign doPop     = en && pop && !push;

    always_comb begin
        wp_d    = wp_q;
        level_d = level_q;
        ovf_d   = clr_err ? 1'b0 : ovf_q;
        unf_d   = clr_err ? 1'b0 : unf_q;
        memWe   = 1'b0;
        memAddr = wp_q;

        if (doPush) begin
            memWe   = 1'b1;
            memAddr = wp_q;
            wp_d    = wp_q + 1'b1;
            if (isFull) begin
                ovf_d = 1'b1;
            end else begin
                level_d = level_q + 1'b1;
            end
        end else if (doReplace) begin
            memWe   = 1'b1;
            memAddr = tosPtr;
        end else if (doPop) begin
            // The pointer moves even on underflow, exposing the older circular entry.
            wp_d = tosPtr;
            if (isEmpty) begin
                unf_d = 1'b1;
            end else begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wp_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (memWe) begin
            mem_q[memAddr] <= IN_PC;
        end
    end

    assign OUT_TOS   = mem_q[tosPtr];
    assign level     = level_q;
    assign empty     = isEmpty;
    assign full      = isFull;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack: hand-computed expectations for push/pop order,
// circular overflow/underflow, replace-top, enable gating, flag clearing and async reset.
module tb_return_stack;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       clrErr = 1'b0;
    logic [9:0] inPc = '0;
    logic [9:0] outTos;
    logic [3:0] level;
    logic       empty, full, overflow, underflow;

    int compareCount = 0;
    int mismatchCount = 0;

    return_stack #(.DEPTH(8), .AW(10), .PW(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .push      (push),
        .pop       (pop),
        .clr_err   (clrErr),
        .IN_PC     (inPc),
        .OUT_TOS   (outTos),
        .level     (level),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag, input logic [9:0] expTos, input logic [3:0] expLevel,
                              input logic expOvf, input logic expUnf);
        checkOutput({tag, ".tos"}, {22'd0, outTos}, {22'd0, expTos});
        checkOutput({tag, ".level"}, {28'd0, level}, {28'd0, expLevel});
        checkOutput({tag, ".empty"}, {31'd0, empty}, {31'd0, (expLevel == 4'd0)});
        checkOutput({tag, ".full"}, {31'd0, full}, {31'd0, (expLevel == 4'd8)});
        checkOutput({tag, ".ovf"}, {31'd0, overflow}, {31'd0, expOvf});
        checkOutput({tag, ".unf"}, {31'd0, underflow}, {31'd0, expUnf});
    endtask

    // Drives one cycle of inputs, lets the rising edge happen, then settles 1ns before returning.
    task automatic applyStimulus(input logic e, input logic pu, input logic po, input logic clr, input logic [9:0] pc);
        en = e;
        push = pu;
        pop = po;
        clrErr = clr;
        inPc = pc;
        @(posedge clock);
        #1;
        en = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        clrErr = 1'b0;
    endtask

    initial begin
        // T1: reset state, then release away from any edge
        #3;
        checkState("t1_inreset", 10'h000, 4'd0, 1'b0, 1'b0);
        #9 reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        checkState("t1_released", 10'h000, 4'd0, 1'b0, 1'b0);

        // T2: LIFO order
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'h010);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'h020);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'h030);
        checkState("t2_pushed", 10'h030, 4'd3, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'h000);
        checkOutput("t2_pop1_tos", {22'd0, outTos}, 32'h020);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'h000);
        checkOutput("t2_pop2_tos", {22'd0, outTos}, 32'h010);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'h000);
        checkOutput("t2_empty", {31'd0, empty}, 32'd1);
        checkOutput("t2_unf", {31'd0, underflow}, 32'd0);

        // T3: nine pushes wrap over the oldest entry; nine pops wrap back around
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'(10'h101 + i));
        end
        checkState("t3_full", 10'h109, 4'd8, 1'b1, 1'b0);
        for (int j = 0; j < 8; j++) begin
            checkOutput($sformatf("t3_pop%0d_tos", j), {22'd0, outTos}, 32'(32'h109 - j));
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'h000);
        end
        checkOutput("t3_drained_level", {28'd0, level}, 32'd0);
        checkOutput("t3_pop9_tos", {22'd0, outTos}, 32'h109);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'h000);
        checkState("t3_underflow", 10'h108, 4'd0, 1'b1, 1'b1);

        // T4: replace top
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'h0AA);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'h0BB);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'h3FF);
        checkState("t4_replace", 10'h3FF, 4'd2, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'h000);
        checkState("t4_pop", 10'h0AA, 4'd1, 1'b1, 1'b1);

        // T5: enable gating, then flag clear independent of en, set-wins on same edge
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, k[0], ~k[0], 1'b0, 10'(10'h155 + k));
        end
        checkState("t5_hold", 10'h0AA, 4'd1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
        checkState("t5_clr", 10'h0AA, 4'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'h000);
        checkOutput("t5_empty", {31'd0, empty}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 10'h000);
        checkOutput("t5_setwins_unf", {31'd0, underflow}, 32'd1);
        checkOutput("t5_setwins_ovf", {31'd0, overflow}, 32'd0);

        // Push+pop on an empty stack behaves as a push
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'h222);
        checkState("emptyreplace", 10'h222, 4'd1, 1'b0, 1'b0);

        // T6: async reset mid-cycle at level 5 with a sticky flag set
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'h000);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'h000);
        for (int m = 0; m < 5; m++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'(10'h040 + m));
        end
        checkState("t6_before", 10'h044, 4'd5, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1;
        checkState("t6_async", 10'h000, 4'd0, 1'b0, 1'b0);
        #3 reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        checkState("t6_after", 10'h000, 4'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
